// File: rtl/tx_wrapper.sv
// Memory-mapped UART transmitter: bus writes fill a byte FIFO that an 8N1 serializer drains.
// Registers: 0 config (write-only), 4 status (read), 8 data push (write).
module tx_wrapper #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       read,
   input  logic       write,
   input  logic [3:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       interrupt,
   output logic       o_Tx_Serial
);

   localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CW-1:0]   BaudLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] FifoFull = CNTW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus decode
   logic cfg_wr, stat_rd, push_req, push, pop;

   assign cfg_wr   = write && (addr == 4'd0);
   assign stat_rd  = read && (addr == 4'd4);
   assign push_req = write && (addr == 4'd8);

   // FIFO
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CNTW-1:0] count_q;
   logic            fifo_empty, fifo_full;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FifoFull);
   // A full FIFO drops the byte even if the serializer pops in the same cycle.
   assign push       = push_req && !fifo_full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Control and status flags
   logic enable_q, irq_q, ovf_q, done;

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= 1'b0;
         irq_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (cfg_wr) begin
            enable_q <= data_in[1];
         end
         if (cfg_wr) begin
            irq_q <= data_in[0];
         end else if (done) begin
            irq_q <= 1'b1;
         end else if (stat_rd) begin
            irq_q <= 1'b0;
         end
         if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
         end else if (stat_rd) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Serializer
   state_e        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_wrap, can_pop;

   assign baud_wrap = (baud_q == BaudLast);
   assign can_pop   = enable_q && !fifo_empty;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (can_pop) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               bit_d   = '0;
               baud_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_wrap) begin
               baud_d  = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_wrap) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_wrap) begin
               done   = 1'b1;
               baud_d = '0;
               // Chain straight into the next frame so queued bytes leave with no idle gap.
               if (can_pop) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rptr_q];
                  bit_d   = '0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Line level is registered from the next state so it tracks state_q exactly.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Outputs
   logic [7:0] status;
   logic       busy;

   assign busy        = (state_q != StIdle);
   assign status      = {2'b00, ovf_q, fifo_full, fifo_empty, busy, enable_q, irq_q};
   assign data_out    = (addr == 4'd4) ? status : 8'h00;
   assign interrupt   = irq_q;
   assign o_Tx_Serial = tx_q;

endmodule

// File: tb/tb_tx_wrapper.sv
// Scoreboarded bench for tx_wrapper: stimulus queues expected bytes, a line monitor decodes
// each 8N1 frame and compares it against the queue.
module tb_tx_wrapper;

   localparam int unsigned CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       interrupt;
   logic       tx_line;

   tx_wrapper #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .interrupt  (interrupt),
      .o_Tx_Serial(tx_line)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  exp_q[$];
   int unsigned start_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Bus tasks start and end just after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      write = 1'b1;
      addr = a;
      data_in = d;
      @(posedge clk);
      #1;
      write = 1'b0;
      addr = 4'd0;
   endtask

   task automatic push(input logic [7:0] d, input bit accepted);
      if (accepted) exp_q.push_back(d);
      bus_write(4'd8, d);
   endtask

   task automatic read_status(output logic [7:0] v);
      read = 1'b1;
      addr = 4'd4;
      @(negedge clk);
      v = data_out;
      @(posedge clk);
      #1;
      read = 1'b0;
      addr = 4'd0;
   endtask

   task automatic drain(input string name);
      logic [7:0] v;
      bit         ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         read_status(v);
         if (v[5:2] == 4'b0010) begin
            ok = 1'b1;
            break;
         end
         idle(5);
      end
      chk(name, ok, 1'b1);
      idle(3);
   endtask

   // Line monitor: decodes each frame sample by sample against the expected waveform.
   initial begin : monitor
      logic [7:0] exp_b, got;
      logic       want;
      int         bad;
      bit         aborted, have_exp;
      forever begin
         @(negedge clk);
         if (!rst && tx_line === 1'b0) begin
            start_q.push_back(cyc);
            have_exp = exp_q.size() > 0;
            exp_b = have_exp ? exp_q[0] : 8'h00;
            bad = 0;
            aborted = 1'b0;
            got = 8'h00;
            for (int s = 0; s < 10; s++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (s != 0 || c != 0) @(negedge clk);
                  if (rst) aborted = 1'b1;
                  want = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp_b[s-1];
                  if (tx_line !== want) bad++;
                  if (s >= 1 && s <= 8 && c == CPB / 2) got[s-1] = tx_line;
               end
            end
            if (!aborted) begin
               chk("frame_expected", have_exp, 1'b1);
               chk("frame_shape", bad, 0);
               chk("frame_byte", got, exp_b);
               if (have_exp) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0]  v, b1, b2;
      int unsigned t0, n_bad, n;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      read_status(v);
      chk("reset_status", v, 8'h08);
      n_bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_line !== 1'b1 || interrupt !== 1'b0) n_bad++;
      end
      idle(1);
      chk("reset_idle_line", n_bad, 0);

      // Single frame 0xA5 with exact start latency and irq timing
      bus_write(4'd0, 8'h02);
      push(8'hA5, 1'b1);
      t0 = cyc;
      idle(40);
      @(negedge clk);
      chk("irq_before_done_edge", interrupt, 1'b0);
      idle(1);
      @(negedge clk);
      chk("irq_after_done_edge", interrupt, 1'b1);
      idle(1);
      chk("a5_start_cycle", (start_q.size() > 0) ? start_q[0] : 0, t0 + 1);
      start_q.delete();
      read_status(v);
      chk("status_irq_set", v, 8'h0B);
      read_status(v);
      chk("status_irq_cleared", v, 8'h0A);

      // Overflow while disabled, then back-to-back drain
      bus_write(4'd0, 8'h00);
      for (int i = 1; i <= 5; i++) push(8'(i), i <= 4);
      read_status(v);
      chk("ovf_status", v, 8'h30);
      read_status(v);
      chk("ovf_cleared", v, 8'h10);
      idle(20);
      chk("disabled_no_frame", start_q.size(), 0);
      bus_write(4'd0, 8'h02);
      t0 = cyc;
      idle(170);
      chk("b2b_frames", start_q.size(), 4);
      if (start_q.size() == 4) begin
         chk("b2b_first_start", start_q[0], t0 + 1);
         for (int k = 1; k < 4; k++) chk("b2b_spacing", start_q[k] - start_q[0], 40 * k);
      end
      start_q.delete();
      read_status(v);
      chk("b2b_status", v, 8'h0B);

      // Status read in the done cycle must not clear irq
      bus_write(4'd0, 8'h02);
      push(8'($urandom), 1'b1);
      idle(40);
      read = 1'b1;
      addr = 4'd4;
      @(negedge clk);
      chk("collide_read_preclear", data_out[0], 1'b0);
      @(posedge clk);
      #1;
      read = 1'b0;
      addr = 4'd0;
      @(negedge clk);
      chk("collide_irq_kept", interrupt, 1'b1);
      idle(2);
      start_q.delete();

      // Reset at data bit 3
      bus_write(4'd0, 8'h00);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      push(b1, 1'b1);
      push(b2, 1'b1);
      bus_write(4'd0, 8'h02);
      idle(16);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      addr = 4'd4;
      @(negedge clk);
      chk("rst_line_high", tx_line, 1'b1);
      chk("rst_status", data_out, 8'h08);
      chk("rst_irq", interrupt, 1'b0);
      idle(1);
      addr = 4'd0;
      idle(100);
      bus_write(4'd0, 8'h02);
      idle(60);
      chk("rst_no_more_frames", start_q.size(), 1);
      read_status(v);
      chk("rst_fifo_flushed", v, 8'h0A);
      start_q.delete();

      // Disable mid-frame: first completes, second stays queued
      bus_write(4'd0, 8'h00);
      push(8'($urandom), 1'b1);
      push(8'($urandom), 1'b1);
      bus_write(4'd0, 8'h02);
      idle(10);
      bus_write(4'd0, 8'h00);
      idle(60);
      read_status(v);
      chk("disable_mid_status", v, 8'h01);
      chk("disable_mid_pending", exp_q.size(), 1);
      bus_write(4'd0, 8'h02);
      idle(60);
      read_status(v);
      chk("reenable_status", v, 8'h0B);

      // Randomized bursts against the byte-queue model
      for (int it = 0; it < 6; it++) begin
         bus_write(4'd0, 8'h00);
         n = $urandom_range(1, 6);
         for (int i = 0; i < int'(n); i++) push(8'($urandom), i < 4);
         read_status(v);
         chk("rand_burst_status", v, ((n > 4) ? 8'h20 : 8'h00) | ((n >= 4) ? 8'h10 : 8'h00));
         bus_write(4'd0, 8'h02);
         drain("rand_burst_drain");
         n = $urandom_range(1, 5);
         for (int i = 0; i < int'(n); i++) push(8'($urandom), 1'b1);
         drain("rand_stream_drain");
      end

      idle(10);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
